// File: rtl/proc_pkg.sv
// Shared register-file definitions used by the write-port arbiter and its pending buffer.
`timescale 1ns/1ps
package proc_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] regnum;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/md_pending_fifo.sv
// Small circular buffer of multiply/divide results waiting for a free register-file write slot.
// Entries can be squashed in place by a younger writeback to the same register.
`timescale 1ns/1ps
module md_pending_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int ADDR_W = proc_pkg::REG_ADDR_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_reg_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              squash_i,
  input  logic [ADDR_W-1:0] squash_reg_i,
  input  logic [ADDR_W-1:0] lookup_reg_i,
  output logic              head_occupied_o,
  output logic              head_valid_o,
  output logic [ADDR_W-1:0] head_reg_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [PTR_W:0]    count_o,
  output logic              pending_hit_o
);
  import proc_pkg::*;

  logic              valid_q  [DEPTH];
  logic [ADDR_W-1:0] regnum_q [DEPTH];
  logic [DATA_W-1:0] data_q   [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [PTR_W:0]    count_q, count_d;
  logic [DEPTH-1:0]  hit_vec;

  assign count_d = count_q + {{PTR_W{1'b0}}, push_i} - {{PTR_W{1'b0}}, pop_i};

  // Later assignments win: pop clears the head, push sets the tail, squash touches the rest.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_i && valid_q[i] && (regnum_q[i] == squash_reg_i)) valid_q[i] <= 1'b0;
      end
      if (pop_i) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (push_i) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      regnum_q[tail_q] <= push_reg_i;
      data_q[tail_q]   <= push_data_i;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign hit_vec[gi] = valid_q[gi] && (regnum_q[gi] == lookup_reg_i);
    end
  endgenerate

  assign pending_hit_o   = (|hit_vec) && (lookup_reg_i != ADDR_W'(REG_ZERO));
  assign head_occupied_o = (count_q != '0);
  assign head_valid_o    = head_occupied_o && valid_q[head_q];
  assign head_reg_o      = regnum_q[head_q];
  assign head_data_o     = data_q[head_q];
  assign count_o         = count_q;
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port: writeback always wins, buffered
// multiply/divide results drain on idle cycles. Output write port is registered.
`timescale 1ns/1ps
module regfile_write_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int ADDR_W = proc_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWriteW,
  input  logic [ADDR_W-1:0] writeRegW,
  input  logic [DATA_W-1:0] resultW,
  input  logic              mdValid,
  output logic              mdReady,
  input  logic [ADDR_W-1:0] mdReg,
  input  logic [DATA_W-1:0] mdData,
  input  logic [ADDR_W-1:0] lookupReg,
  output logic              pendingHit,
  output logic              rfWriteEnable,
  output logic [ADDR_W-1:0] rfWriteAddr,
  output logic [DATA_W-1:0] rfWriteData
);
  import proc_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic              wb_req, push, pop;
  logic              head_occupied, head_valid;
  logic [ADDR_W-1:0] head_reg;
  logic [DATA_W-1:0] head_data;
  logic [PTR_W:0]    count;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign wb_req  = regWriteW && (writeRegW != ADDR_W'(REG_ZERO));
  // Ready looks only at the registered count so it has no path from pop or WB.
  assign mdReady = !reset && (count < (PTR_W+1)'(DEPTH));
  assign push    = mdValid && mdReady && (mdReg != ADDR_W'(REG_ZERO));
  // Squashed heads retire even when WB owns the port.
  assign pop     = head_occupied && (!head_valid || !wb_req);

  md_pending_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk             (clk),
    .reset           (reset),
    .push_i          (push),
    .push_reg_i      (mdReg),
    .push_data_i     (mdData),
    .pop_i           (pop),
    .squash_i        (wb_req),
    .squash_reg_i    (writeRegW),
    .lookup_reg_i    (lookupReg),
    .head_occupied_o (head_occupied),
    .head_valid_o    (head_valid),
    .head_reg_o      (head_reg),
    .head_data_o     (head_data),
    .count_o         (count),
    .pending_hit_o   (pendingHit)
  );

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (wb_req) begin
      we_d   = 1'b1;
      addr_d = writeRegW;
      data_d = resultW;
    end else if (head_valid) begin
      we_d   = 1'b1;
      addr_d = head_reg;
      data_d = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign rfWriteEnable = we_q;
  assign rfWriteAddr   = addr_q;
  assign rfWriteData   = data_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for the register-file write arbiter: reset, WB path, starvation/drain,
// squash, same-edge push/pop, register-zero handling and mid-operation reset.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;
  logic        clk;
  logic        reset;
  logic        regWriteW;
  logic [4:0]  writeRegW;
  logic [31:0] resultW;
  logic        mdValid;
  logic        mdReady;
  logic [4:0]  mdReg;
  logic [31:0] mdData;
  logic [4:0]  lookupReg;
  logic        pendingHit;
  logic        rfWriteEnable;
  logic [4:0]  rfWriteAddr;
  logic [31:0] rfWriteData;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.DEPTH(2), .DATA_W(32), .ADDR_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .regWriteW     (regWriteW),
    .writeRegW     (writeRegW),
    .resultW       (resultW),
    .mdValid       (mdValid),
    .mdReady       (mdReady),
    .mdReg         (mdReg),
    .mdData        (mdData),
    .lookupReg     (lookupReg),
    .pendingHit    (pendingHit),
    .rfWriteEnable (rfWriteEnable),
    .rfWriteAddr   (rfWriteAddr),
    .rfWriteData   (rfWriteData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rfWriteEnable === 1'b1)
      $display("[%0t] rf write r%0d <= %h", $time, rfWriteAddr, rfWriteData);
  endtask

  task automatic test_reset();
    reset = 1'b1; mdValid = 1'b1; mdReg = 5'd4; mdData = 32'h44;
    step(); step();
    checks++; if (mdReady !== 1'b0) begin errors++; $display("FAIL rst_mdReady: got %b want 0", mdReady); end
    checks++; if (rfWriteEnable !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", rfWriteEnable); end
    checks++; if (rfWriteAddr !== 5'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", rfWriteAddr); end
    checks++; if (rfWriteData !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", rfWriteData); end
    reset = 1'b0; mdValid = 1'b0; lookupReg = 5'd5;
    #1;
    checks++; if (mdReady !== 1'b1) begin errors++; $display("FAIL rst_rel_mdReady: got %b want 1", mdReady); end
    checks++; if (pendingHit !== 1'b0) begin errors++; $display("FAIL rst_rel_hit5: got %b want 0", pendingHit); end
    step();
    checks++; if (rfWriteEnable !== 1'b0) begin errors++; $display("FAIL rst_rel_we: got %b want 0", rfWriteEnable); end
  endtask

  task automatic test_wb_only();
    regWriteW = 1'b1; writeRegW = 5'd3; resultW = 32'hDEADBEEF;
    step();
    checks++; if (rfWriteEnable !== 1'b1) begin errors++; $display("FAIL wb_we: got %b want 1", rfWriteEnable); end
    checks++; if (rfWriteAddr !== 5'd3) begin errors++; $display("FAIL wb_addr: got %0d want 3", rfWriteAddr); end
    checks++; if (rfWriteData !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_data: got %h want deadbeef", rfWriteData); end
    writeRegW = 5'd0; resultW = 32'h12345678;
    step();
    checks++; if (rfWriteEnable !== 1'b0) begin errors++; $display("FAIL wb_r0_we: got %b want 0", rfWriteEnable); end
    checks++; if (rfWriteAddr !== 5'd3) begin errors++; $display("FAIL wb_hold_addr: got %0d want 3", rfWriteAddr); end
    checks++; if (rfWriteData !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_hold_data: got %h want deadbeef", rfWriteData); end
    regWriteW = 1'b0;
  endtask

  task automatic test_starve_drain();
    regWriteW = 1'b1; writeRegW = 5'd1; resultW = 32'hA0;
    mdValid = 1'b1; mdReg = 5'd7; mdData = 32'h11;
    step();
    checks++; if (mdReady !== 1'b1) begin errors++; $display("FAIL sd_ready_c1: got %b want 1", mdReady); end
    mdReg = 5'd8; mdData = 32'h22;
    step();
    mdReg = 5'd12; mdData = 32'hCC; lookupReg = 5'd7;
    #1;
    checks++; if (mdReady !== 1'b0) begin errors++; $display("FAIL sd_full_ready: got %b want 0", mdReady); end
    checks++; if (pendingHit !== 1'b1) begin errors++; $display("FAIL sd_hit7: got %b want 1", pendingHit); end
    checks++; if (rfWriteAddr !== 5'd1) begin errors++; $display("FAIL sd_wb_addr: got %0d want 1", rfWriteAddr); end
    step();
    checks++; if (mdReady !== 1'b0) begin errors++; $display("FAIL sd_full_hold: got %b want 0", mdReady); end
    mdValid = 1'b0; regWriteW = 1'b0;
    step();
    checks++; if ({rfWriteEnable, rfWriteAddr, rfWriteData} !== {1'b1, 5'd7, 32'h11}) begin errors++; $display("FAIL sd_drain1: got %b/%0d/%h want 1/7/11", rfWriteEnable, rfWriteAddr, rfWriteData); end
    checks++; if (mdReady !== 1'b1) begin errors++; $display("FAIL sd_ready_after_pop: got %b want 1", mdReady); end
    step();
    checks++; if ({rfWriteEnable, rfWriteAddr, rfWriteData} !== {1'b1, 5'd8, 32'h22}) begin errors++; $display("FAIL sd_drain2: got %b/%0d/%h want 1/8/22", rfWriteEnable, rfWriteAddr, rfWriteData); end
    step();
    checks++; if (rfWriteEnable !== 1'b0) begin errors++; $display("FAIL sd_no_overflow_write: got %b/%0d want 0", rfWriteEnable, rfWriteAddr); end
    checks++; if (pendingHit !== 1'b0) begin errors++; $display("FAIL sd_hit7_clear: got %b want 0", pendingHit); end
  endtask

  task automatic test_squash();
    mdValid = 1'b1; mdReg = 5'd9; mdData = 32'h55; lookupReg = 5'd9;
    step();
    mdValid = 1'b0; regWriteW = 1'b1; writeRegW = 5'd9; resultW = 32'h66;
    #1;
    checks++; if (pendingHit !== 1'b1) begin errors++; $display("FAIL sq_hit_before: got %b want 1", pendingHit); end
    step();
    regWriteW = 1'b0;
    checks++; if ({rfWriteEnable, rfWriteAddr, rfWriteData} !== {1'b1, 5'd9, 32'h66}) begin errors++; $display("FAIL sq_wb_write: got %b/%0d/%h want 1/9/66", rfWriteEnable, rfWriteAddr, rfWriteData); end
    checks++; if (pendingHit !== 1'b0) begin errors++; $display("FAIL sq_hit_after: got %b want 0", pendingHit); end
    step();
    checks++; if (rfWriteEnable !== 1'b0) begin errors++; $display("FAIL sq_no_md_write: got %b/%0d/%h want 0", rfWriteEnable, rfWriteAddr, rfWriteData); end
    step();
    checks++; if (rfWriteEnable !== 1'b0) begin errors++; $display("FAIL sq_idle: got %b want 0", rfWriteEnable); end
  endtask

  task automatic test_push_pop();
    mdValid = 1'b1; mdReg = 5'd11; mdData = 32'h33; lookupReg = 5'd10;
    step();
    checks++; if (rfWriteEnable !== 1'b0) begin errors++; $display("FAIL pp_no_bypass: got %b want 0", rfWriteEnable); end
    mdReg = 5'd10; mdData = 32'h77;
    step();
    mdValid = 1'b0;
    checks++; if ({rfWriteEnable, rfWriteAddr, rfWriteData} !== {1'b1, 5'd11, 32'h33}) begin errors++; $display("FAIL pp_head: got %b/%0d/%h want 1/11/33", rfWriteEnable, rfWriteAddr, rfWriteData); end
    checks++; if (pendingHit !== 1'b1) begin errors++; $display("FAIL pp_hit10: got %b want 1", pendingHit); end
    checks++; if (mdReady !== 1'b1) begin errors++; $display("FAIL pp_ready: got %b want 1", mdReady); end
    step();
    checks++; if ({rfWriteEnable, rfWriteAddr, rfWriteData} !== {1'b1, 5'd10, 32'h77}) begin errors++; $display("FAIL pp_next: got %b/%0d/%h want 1/10/77", rfWriteEnable, rfWriteAddr, rfWriteData); end
    step();
    checks++; if (rfWriteEnable !== 1'b0) begin errors++; $display("FAIL pp_empty: got %b want 0", rfWriteEnable); end
  endtask

  task automatic test_reg_zero();
    mdValid = 1'b1; mdReg = 5'd0; mdData = 32'h99; lookupReg = 5'd0;
    #1;
    checks++; if (mdReady !== 1'b1) begin errors++; $display("FAIL rz_ready: got %b want 1", mdReady); end
    step();
    mdValid = 1'b0;
    checks++; if (pendingHit !== 1'b0) begin errors++; $display("FAIL rz_hit0: got %b want 0", pendingHit); end
    step();
    checks++; if (rfWriteEnable !== 1'b0) begin errors++; $display("FAIL rz_no_write: got %b/%0d want 0", rfWriteEnable, rfWriteAddr); end
  endtask

  task automatic test_reset_mid();
    regWriteW = 1'b1; writeRegW = 5'd1; resultW = 32'hB0;
    mdValid = 1'b1; mdReg = 5'd7; mdData = 32'h11;
    step();
    mdReg = 5'd8; mdData = 32'h22;
    step();
    mdValid = 1'b0; lookupReg = 5'd8;
    #1;
    checks++; if (mdReady !== 1'b0) begin errors++; $display("FAIL rm_full: got %b want 0", mdReady); end
    reset = 1'b1; regWriteW = 1'b0;
    step();
    checks++; if (rfWriteEnable !== 1'b0) begin errors++; $display("FAIL rm_we_in_reset: got %b want 0", rfWriteEnable); end
    checks++; if (pendingHit !== 1'b0) begin errors++; $display("FAIL rm_hit_cleared: got %b want 0", pendingHit); end
    reset = 1'b0;
    #1;
    checks++; if (mdReady !== 1'b1) begin errors++; $display("FAIL rm_ready_release: got %b want 1", mdReady); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (rfWriteEnable !== 1'b0) begin errors++; $display("FAIL rm_no_stale_write%0d: got %b/%0d/%h want 0", i, rfWriteEnable, rfWriteAddr, rfWriteData); end
    end
  endtask

  initial begin
    reset = 1'b1; regWriteW = 1'b0; writeRegW = '0; resultW = '0;
    mdValid = 1'b0; mdReg = '0; mdData = '0; lookupReg = '0;
    test_reset();
    test_wb_only();
    test_starve_drain();
    test_squash();
    test_push_pop();
    test_reg_zero();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
